// File: rtl/stump_pkg.sv
// Shared definitions for the Stump control path: opcodes, ALU and shift
// codes, branch condition codes, state encoding and flag bit positions.
package stump_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADC  = 3'b001,
    OP_SUB  = 3'b010,
    OP_SBC  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_LDST = 3'b110,
    OP_BCC  = 3'b111
  } opcode_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_ADC = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SBC = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;

  localparam logic [1:0] SHIFT_NONE = 2'b00;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,  COND_NV = 4'd1,
    COND_HI = 4'd2,  COND_LS = 4'd3,
    COND_CC = 4'd4,  COND_CS = 4'd5,
    COND_NE = 4'd6,  COND_EQ = 4'd7,
    COND_VC = 4'd8,  COND_VS = 4'd9,
    COND_PL = 4'd10, COND_MI = 4'd11,
    COND_GE = 4'd12, COND_LT = 4'd13,
    COND_GT = 4'd14, COND_LE = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_MEMORY  = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // R7 is the program counter.
  localparam logic [2:0] REG_PC = 3'd7;

endpackage

// File: rtl/stump_control_if.sv
// Control <-> datapath bundle. The control block drives the decode outputs
// and takes the instruction register and flags back from the datapath.
interface stump_control_if;
  logic [15:0] ir;
  logic [3:0]  cc;
  logic        fetch;
  logic        execute;
  logic        memory;
  logic        ext_op;
  logic        opB_mux_sel;
  logic [1:0]  shift_op;
  logic [2:0]  alu_func;
  logic        cc_en;
  logic        reg_write;
  logic [2:0]  dest;
  logic [2:0]  srcA;
  logic [2:0]  srcB;
  logic        mem_wen;
  logic        mem_ren;
  logic [15:0] instr_count;
  logic [15:0] cycle_count;

  modport master (
    input  ir, cc,
    output fetch, execute, memory, ext_op, opB_mux_sel, shift_op, alu_func,
           cc_en, reg_write, dest, srcA, srcB, mem_wen, mem_ren,
           instr_count, cycle_count
  );

  modport slave (
    output ir, cc,
    input  fetch, execute, memory, ext_op, opB_mux_sel, shift_op, alu_func,
           cc_en, reg_write, dest, srcA, srcB, mem_wen, mem_ren,
           instr_count, cycle_count
  );
endinterface

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator: 4-bit condition code plus NZVC flags -> taken.
module stump_cond_eval
  import stump_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       taken
);

  logic n, z, v, c;

  assign n = cc[FLAG_N];
  assign z = cc[FLAG_Z];
  assign v = cc[FLAG_V];
  assign c = cc[FLAG_C];

  // Evaluate the selected condition against the current flags.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      COND_HI: taken = ~c & ~z;
      COND_LS: taken = c | z;
      COND_CC: taken = ~c;
      COND_CS: taken = c;
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_VC: taken = ~v;
      COND_VS: taken = v;
      COND_PL: taken = ~n;
      COND_MI: taken = n;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/stump_control.sv
// Stump control block: fetch/execute/memory sequencer plus combinational
// decode of the instruction register into datapath controls.
// Optional macro STUMP_CONTROL_PERF_EN adds cycle and retired-instruction
// counters; without it both count outputs are tied to zero.
module stump_control
  import stump_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  stump_control_if.master bus
);

  state_e state;
  state_e next_state;

  logic [2:0] opcode;
  logic       imm_type;
  logic       s_bit;
  logic       is_ldst;
  logic       is_bcc;
  logic       taken;

  assign opcode   = bus.ir[15:13];
  assign imm_type = bus.ir[12];
  assign s_bit    = bus.ir[11];
  assign is_ldst  = (opcode == OP_LDST);
  assign is_bcc   = (opcode == OP_BCC);

  stump_cond_eval u_cond_eval (
    .cond  (bus.ir[11:8]),
    .cc    (bus.cc),
    .taken (taken)
  );

  // State register; reset returns to FETCH and aborts any instruction.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= next_state;
  end

  // Next-state: loads and stores take an extra MEMORY cycle.
  always_comb begin
    next_state = ST_FETCH;
    case (state)
      ST_FETCH:   next_state = ST_EXECUTE;
      ST_EXECUTE: next_state = is_ldst ? ST_MEMORY : ST_FETCH;
      ST_MEMORY:  next_state = ST_FETCH;
      default:    next_state = ST_FETCH;
    endcase
  end

  // Decode outputs; everything not driven for a state stays 0.
  always_comb begin
    bus.fetch       = 1'b0;
    bus.execute     = 1'b0;
    bus.memory      = 1'b0;
    bus.ext_op      = 1'b0;
    bus.opB_mux_sel = 1'b0;
    bus.shift_op    = SHIFT_NONE;
    bus.alu_func    = ALU_ADD;
    bus.cc_en       = 1'b0;
    bus.reg_write   = 1'b0;
    bus.dest        = 3'd0;
    bus.srcA        = 3'd0;
    bus.srcB        = 3'd0;
    bus.mem_wen     = 1'b0;
    bus.mem_ren     = 1'b0;
    case (state)
      ST_FETCH: begin
        // PC increment; ir is not yet valid so nothing here looks at it.
        bus.fetch     = 1'b1;
        bus.srcA      = REG_PC;
        bus.dest      = REG_PC;
        bus.reg_write = 1'b1;
        bus.mem_ren   = 1'b1;
      end
      ST_EXECUTE: begin
        bus.execute = 1'b1;
        if (is_bcc) begin
          bus.srcA        = REG_PC;
          bus.dest        = REG_PC;
          bus.opB_mux_sel = 1'b1;
          bus.ext_op      = 1'b1;
          bus.reg_write   = taken;
        end else begin
          // LD/ST reuse the ALU path with ADD to form the effective address.
          bus.alu_func  = is_ldst ? ALU_ADD : opcode;
          bus.dest      = bus.ir[10:8];
          bus.srcA      = bus.ir[7:5];
          bus.reg_write = ~is_ldst;
          bus.cc_en     = ~is_ldst & s_bit;
          if (imm_type) begin
            bus.opB_mux_sel = 1'b1;
          end else begin
            bus.srcB     = bus.ir[4:2];
            bus.shift_op = bus.ir[1:0];
          end
        end
      end
      ST_MEMORY: begin
        bus.memory = 1'b1;
        if (s_bit) begin
          bus.srcA    = bus.ir[10:8];
          bus.mem_wen = 1'b1;
        end else begin
          bus.dest      = bus.ir[10:8];
          bus.reg_write = 1'b1;
          bus.mem_ren   = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef STUMP_CONTROL_PERF_EN
  logic [15:0] cycle_cnt_q;
  logic [15:0] instr_cnt_q;

  // Performance counters; an instruction retires on any return to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= 16'd0;
      instr_cnt_q <= 16'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
      if ((state != ST_FETCH) && (next_state == ST_FETCH))
        instr_cnt_q <= instr_cnt_q + 16'd1;
    end
  end

  assign bus.cycle_count = cycle_cnt_q;
  assign bus.instr_count = instr_cnt_q;
`else
  assign bus.cycle_count = 16'd0;
  assign bus.instr_count = 16'd0;
`endif

endmodule

// File: doc/stump_control.md
# stump_control

Control block for the Stump processor. It sequences the fetch/execute/memory state machine and decodes the instruction register into every control input of the Stump datapath: operand selects, ALU function, shift operation, register-bank addresses and write enables, flag-update enable and memory strobes. It sits directly upstream of the datapath, takes `ir` and `cc` back from it, and evaluates branch conditions.

## Interface
Parameters:
- none

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  master reset; synchronous, active-high
- `ir`  input  16  instruction register from the datapath
- `cc`  input  4  flags from the datapath: N=`cc[3]`, Z=`cc[2]`, V=`cc[1]`, C=`cc[0]`
- `fetch`, `execute`, `memory`  output  1 each  one-hot state indicators
- `ext_op`  output  1  1 selects the 8-bit sign-extended immediate, 0 selects the 5-bit one
- `opB_mux_sel`  output  1  1 selects the immediate for operand B
- `shift_op`  output  2  shifter operation
- `alu_func`  output  3  ALU function
- `cc_en`  output  1  flag register write enable
- `reg_write`  output  1  register bank write enable
- `dest`, `srcA`, `srcB`  output  3 each  register bank addresses
- `mem_wen`  output  1  memory write strobe
- `mem_ren`  output  1  memory read strobe
- `instr_count`  output  16  retired-instruction counter (see Configuration)
- `cycle_count`  output  16  cycle counter (see Configuration)

## Operation
**Instruction fields**
- `ir[15:13]` opcode: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 LD/ST, 111 Bcc.
- `ir[12]` type: 0 = register, 1 = immediate.
- `ir[11]` S bit; for LD/ST it is 0 = load, 1 = store.
- `ir[10:8]` destination, `ir[7:5]` srcA, `ir[4:2]` srcB, `ir[1:0]` shift.

**State machine**
- FETCH → EXECUTE always.
- EXECUTE → MEMORY if opcode is 110, otherwise → FETCH.
- MEMORY → FETCH.

**FETCH**
- `srcA` = 7, `dest` = 7, `alu_func` = 000, `shift_op` = 00, `reg_write` = 1.
- `cc_en` = 0, `mem_ren` = 1. This is the PC increment; the datapath forces operand B to 1.

**EXECUTE, ALU ops (opcode 0xx, 100, 101)**
- `alu_func` = opcode, `dest`/`srcA` from their fields.
- Type 0: `srcB` = `ir[4:2]`, `shift_op` = `ir[1:0]`, `opB_mux_sel` = 0.
- Type 1: `opB_mux_sel` = 1, `ext_op` = 0, `shift_op` = 00.
- `reg_write` = 1; `cc_en` = `ir[11]`.

**EXECUTE, LD/ST**
- `alu_func` = 000, operands as for ALU ops (effective address).
- `reg_write` = 0, `cc_en` = 0.

**EXECUTE, Bcc**
- `srcA` = 7, `dest` = 7, `opB_mux_sel` = 1, `ext_op` = 1, `alu_func` = 000, `shift_op` = 00, `cc_en` = 0.
- `reg_write` = condition taken.
- Conditions on `ir[11:8]`, in order 0–15:
  - AL (1), NV (0)
  - HI (!C&!Z), LS (C|Z), CC (!C), CS (C)
  - NE (!Z), EQ (Z), VC (!V), VS (V)
  - PL (!N), MI (N)
  - GE (N==V), LT (N!=V), GT (!Z&(N==V)), LE (Z|(N!=V))

**MEMORY**
- Load: `dest` = `ir[10:8]`, `reg_write` = 1, `mem_ren` = 1.
- Store: `srcA` = `ir[10:8]` (drives data out), `reg_write` = 0, `mem_wen` = 1.
- `cc_en` = 0.

**Defaults**
- Every output not listed for a state is 0, including address fields.
- Unlisted control outputs are 0 in every state; FETCH drives `ext_op`, `opB_mux_sel`, `srcB` and `mem_wen` to 0.

## Timing
- The state register is the only control flop. All decode outputs are combinational from state, `ir` and `cc`.
- Cycles per instruction: 2 for ALU ops and Bcc, 3 for LD/ST.
- `ir` is valid from the cycle after FETCH; decode in FETCH must not depend on `ir`.
- Reset: state = FETCH, so `fetch` = 1 and `execute` = `memory` = 0. Counters = 0. Decode outputs take their FETCH values.
- `rst` asserted mid-instruction (EXECUTE or MEMORY) aborts it; the next cycle is FETCH with no write strobes.
- Branch condition samples `cc` as registered before EXECUTE. An S-bit ALU op followed by a branch sees the updated flags.

## Configuration
- Macro `STUMP_CONTROL_PERF_EN`.
- Defined:
  - `cycle_count` increments every cycle not in reset.
  - `instr_count` increments on each EXECUTE→FETCH or MEMORY→FETCH transition.
  - Both wrap from 0xFFFF to 0x0000.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package `stump_pkg` holds:
  - opcode constants;
  - ALU function codes;
  - shift codes (00 none);
  - condition codes;
  - state encoding (FETCH, EXECUTE, MEMORY);
  - flag bit indices.
- One sub-module, `stump_cond_eval`: combinational, 4-bit condition plus `cc` → taken.

## Test plan
- Reset then release: `fetch`=1, `srcA`=`dest`=7, `reg_write`=1. The next cycle has `execute`=1.
- `ir` = 0x4A44 (SUB, S=1, R2, R2, R1, shift 00) in EXECUTE → `alu_func`=010, `cc_en`=1, `opB_mux_sel`=0, `dest`=2, `srcA`=2, `srcB`=1. The next state is FETCH.
- LD `ir` = 0xD125 (type 1, load R1 ← [R1+5]): EXECUTE `alu_func`=000, `opB_mux_sel`=1, `reg_write`=0. MEMORY `dest`=1, `reg_write`=1, `mem_ren`=1. Total 3 cycles.
- ST `ir` = 0xDA25: MEMORY `srcA`=2, `mem_wen`=1, `reg_write`=0.
- BEQ `ir` = 0xE7FE: `cc`=0100 → `reg_write`=1, `ext_op`=1, `dest`=7. `cc`=0000 → `reg_write`=0. Sweep all 16 conditions × 16 `cc` values against the table.
- `rst` asserted during MEMORY of a store → next cycle FETCH, `mem_wen`=0. With `STUMP_CONTROL_PERF_EN`, counters read 0, and after 0x10000 instructions `instr_count` wraps to 0.
